// File: rtl/rule_seq_pkg.sv
// Shared CSR map, command bits, sequencer states and word-count helper for the rule loader.
package rule_seq_pkg;

  localparam logic [3:0] ADDR_VALUE0 = 4'h0;
  localparam logic [3:0] ADDR_MASK0  = 4'h4;
  localparam logic [3:0] ADDR_CMD    = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'h9;
  localparam logic [3:0] ADDR_ERRCLR = 4'hA;

  localparam int CMD_COMMIT = 0;
  localparam int CMD_CLEAR  = 1;

  typedef enum logic [1:0] {IDLE, ZERO, ONE, DONE} seq_state_t;

  function automatic int calc_nw(input int width);
    return (width + 31) / 32;
  endfunction

endpackage

// File: rtl/rule_word_serializer.sv
// Emits the NW 32-bit words of a vector, LSW first, with WR_GAP idle cycles between writes.
// A start coinciding with the final word chains the next vector while keeping the pacing gap.
module rule_word_serializer #(
  parameter int NW     = 4,
  parameter int WR_GAP = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [NW*32-1:0] vec,
  output logic             word_write,
  output logic [31:0]      word_data,
  output logic             word_last,
  output logic             done
);

  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int GW = $clog2(WR_GAP + 1) + 1;

  logic          active;
  logic [IW-1:0] idx;
  logic [GW-1:0] gap_cnt;

  assign word_write = active && (gap_cnt == '0);
  assign word_last  = word_write && (idx == IW'(NW - 1));
  assign word_data  = word_write ? vec[32*int'(idx) +: 32] : 32'h0;
  assign done       = word_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active  <= 1'b0;
      idx     <= '0;
      gap_cnt <= '0;
    end else begin
      if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      if (word_write) begin
        gap_cnt <= GW'(WR_GAP);
        idx     <= idx + 1'b1;
        if (word_last) active <= 1'b0;
      end
      // A fresh start writes on the next cycle; a chained start honours the gap.
      if (start) begin
        active  <= 1'b1;
        idx     <= '0;
        gap_cnt <= word_write ? GW'(WR_GAP) : '0;
      end
    end
  end

endmodule

// File: rtl/rule_update_sequencer.sv
// Host CSR rule loader: stages a ternary rule, expands it to zeros/ones vectors and streams them
// to the match block's update port, counting loaded rules and refusing commits when full.
module rule_update_sequencer
  import rule_seq_pkg::*;
#(
  parameter int CONCAT_WIDTH = 120,
  parameter int RCOUNT       = 104,
  parameter int WR_GAP       = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  avs_csr_address,
  input  logic        avs_csr_write,
  input  logic [31:0] avs_csr_writedata,
  input  logic        avs_csr_read,
  output logic [31:0] avs_csr_readdata,
  output logic        avs_csr_waitrequest,
  output logic        upd_write,
  output logic [31:0] upd_writedata,
  output logic        upd_address,
  output logic        table_clear
);

  localparam int NW = calc_nw(CONCAT_WIDTH);
  localparam int VW = NW * 32;
  localparam int CW = $clog2(RCOUNT + 1);
  localparam logic [VW-1:0] KEY_MASK = ~({VW{1'b1}} << CONCAT_WIDTH);

  seq_state_t    state, state_nxt;
  logic [VW-1:0] val_stage, mask_stage, val_snap, mask_snap;
  logic [VW-1:0] zeros_vec, ones_vec;
  logic [CW-1:0] count;
  logic          err, busy, full, word_ok;
  logic          cmd_wr, errclr_wr, wr_ok;
  logic          start, snap, cnt_inc, cnt_clr, err_set, clr_pulse, ser_done;
  logic [31:0]   rd_mux;

  assign busy    = (state != IDLE);
  assign full    = (count == CW'(RCOUNT));
  assign word_ok = (int'(avs_csr_address[1:0]) < NW);

  assign avs_csr_waitrequest = busy && avs_csr_write && (avs_csr_address <= ADDR_CMD);
  assign wr_ok     = avs_csr_write && !avs_csr_waitrequest;
  assign cmd_wr    = wr_ok && (avs_csr_address == ADDR_CMD);
  assign errclr_wr = wr_ok && (avs_csr_address == ADDR_ERRCLR);

  assign zeros_vec = (~mask_snap | ~val_snap) & KEY_MASK;
  assign ones_vec  = (~mask_snap |  val_snap) & KEY_MASK;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      val_stage  <= '0;
      mask_stage <= '0;
    end else if (wr_ok && word_ok) begin
      if (avs_csr_address[3:2] == ADDR_VALUE0[3:2])
        val_stage[32*int'(avs_csr_address[1:0]) +: 32] <= avs_csr_writedata;
      else if (avs_csr_address[3:2] == ADDR_MASK0[3:2])
        mask_stage[32*int'(avs_csr_address[1:0]) +: 32] <= avs_csr_writedata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      val_snap  <= '0;
      mask_snap <= '0;
    end else if (snap) begin
      val_snap  <= val_stage;
      mask_snap <= mask_stage;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    snap      = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    err_set   = 1'b0;
    clr_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_wr) begin
          // CLEAR takes priority; a COMMIT riding along with it is dropped and flagged.
          if (avs_csr_writedata[CMD_CLEAR]) begin
            cnt_clr   = 1'b1;
            clr_pulse = 1'b1;
            err_set   = avs_csr_writedata[CMD_COMMIT];
          end else if (avs_csr_writedata[CMD_COMMIT]) begin
            if (full) begin
              err_set = 1'b1;
            end else begin
              snap      = 1'b1;
              start     = 1'b1;
              state_nxt = ZERO;
            end
          end
        end
      end
      ZERO: begin
        if (ser_done) begin
          start     = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE:  if (ser_done) state_nxt = DONE;
      DONE: begin
        cnt_inc   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count       <= '0;
      err         <= 1'b0;
      table_clear <= 1'b0;
    end else begin
      table_clear <= clr_pulse;
      if (cnt_clr)                count <= '0;
      else if (cnt_inc && !full)  count <= count + 1'b1;
      if (err_set)                err <= 1'b1;
      else if (errclr_wr)         err <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    if (avs_csr_address == ADDR_STATUS)
      rd_mux = {16'h0, 8'(count), 5'h0, err, full, busy};
    else if (word_ok && avs_csr_address[3:2] == ADDR_VALUE0[3:2])
      rd_mux = val_stage[32*int'(avs_csr_address[1:0]) +: 32];
    else if (word_ok && avs_csr_address[3:2] == ADDR_MASK0[3:2])
      rd_mux = mask_stage[32*int'(avs_csr_address[1:0]) +: 32];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)             avs_csr_readdata <= 32'h0;
    else if (avs_csr_read) avs_csr_readdata <= rd_mux;
    else                   avs_csr_readdata <= 32'h0;
  end

  rule_word_serializer #(
    .NW     (NW),
    .WR_GAP (WR_GAP)
  ) u_ser (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .vec        ((state == ONE) ? ones_vec : zeros_vec),
    .word_write (upd_write),
    .word_data  (upd_writedata),
    .word_last  (upd_address),
    .done       (ser_done)
  );

endmodule

// File: tb/tb_rule_update_sequencer.sv
// Randomized scoreboard bench for rule_update_sequencer, plus a WR_GAP=3 instance for pacing.
module tb_rule_update_sequencer;

  localparam int CWID = 120;
  localparam int RC   = 104;
  localparam int NWD  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  addr;
  logic        write, read;
  logic [31:0] wdata, readdata;
  logic        waitreq, upd_write, upd_addr, tclr;
  logic [31:0] upd_wdata;

  logic [3:0]  p_addr;
  logic        p_write, p_read;
  logic [31:0] p_wdata, p_readdata;
  logic        p_waitreq, p_upd_write, p_upd_addr, p_tclr;
  logic [31:0] p_upd_wdata;

  always #5 clock = ~clock;

  rule_update_sequencer #(.CONCAT_WIDTH(CWID), .RCOUNT(RC), .WR_GAP(1)) dut (
    .clock(clock), .reset(reset),
    .avs_csr_address(addr), .avs_csr_write(write), .avs_csr_writedata(wdata),
    .avs_csr_read(read), .avs_csr_readdata(readdata), .avs_csr_waitrequest(waitreq),
    .upd_write(upd_write), .upd_writedata(upd_wdata), .upd_address(upd_addr),
    .table_clear(tclr)
  );

  rule_update_sequencer #(.CONCAT_WIDTH(CWID), .RCOUNT(RC), .WR_GAP(3)) dut_pace (
    .clock(clock), .reset(reset),
    .avs_csr_address(p_addr), .avs_csr_write(p_write), .avs_csr_writedata(p_wdata),
    .avs_csr_read(p_read), .avs_csr_readdata(p_readdata), .avs_csr_waitrequest(p_waitreq),
    .upd_write(p_upd_write), .upd_writedata(p_upd_wdata), .upd_address(p_upd_addr),
    .table_clear(p_tclr)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  // Reference model state
  typedef struct {logic [31:0] d; logic a; bit first;} exp_t;
  exp_t         expq[$];
  logic [127:0] m_val, m_mask;
  int           m_count, m_err, tclr_exp;
  int           accept_cyc, last_wr_cyc;
  int           wr_seen = 0;
  int           tclr_seen = 0;
  int           p_times[$];

  task automatic push_rule(input logic [127:0] v, input logic [127:0] m);
    logic [127:0] keep, z, o;
    keep = (128'd1 << CWID) - 128'd1;
    z = (~m | ~v) & keep;
    o = (~m | v) & keep;
    for (int w = 0; w < NWD; w++) expq.push_back('{z[32*w +: 32], w == NWD-1, w == 0});
    for (int w = 0; w < NWD; w++) expq.push_back('{o[32*w +: 32], w == NWD-1, 1'b0});
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (tclr) tclr_seen++;
    if (upd_write) begin
      wr_seen++;
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got data 0x%08h, required no write", upd_wdata);
      end else begin
        e = expq.pop_front();
        chk("upd_writedata", upd_wdata, e.d);
        chk("upd_address", {31'h0, upd_addr}, {31'h0, e.a});
        if (e.first) chk("first_write_latency", 32'(cyc), 32'(accept_cyc + 1));
        else         chk("write_spacing", 32'(cyc - last_wr_cyc), 32'd2);
      end
      last_wr_cyc = cyc;
    end
  end

  always @(negedge clock) if (p_upd_write) p_times.push_back(cyc);

  task automatic csr_wr(input logic [3:0] a, input logic [31:0] d, output int acc);
    bit ok;
    ok = 0;
    acc = -1;
    @(posedge clock); #1;
    addr = a; wdata = d; write = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      if (!waitreq) begin
        ok = 1;
        acc = cyc;
        accept_cyc = cyc;
      end
    end
    @(posedge clock); #1;
    write = 1'b0;
    if (!ok) timeout("csr_write_accept");
  endtask

  task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
    @(posedge clock); #1;
    addr = a; read = 1'b1;
    @(posedge clock); #1;
    read = 1'b0;
    d = readdata;
  endtask

  task automatic stage(input logic [127:0] v, input logic [127:0] m);
    int acc;
    for (int w = 0; w < NWD; w++) csr_wr(4'(w), v[32*w +: 32], acc);
    for (int w = 0; w < NWD; w++) csr_wr(4'(4 + w), m[32*w +: 32], acc);
    m_val = v;
    m_mask = m;
  endtask

  task automatic do_cmd(input logic [1:0] c, output int acc);
    if (c[1]) begin
      m_count = 0;
      tclr_exp++;
      if (c[0]) m_err = 1;
    end else if (c[0]) begin
      if (m_count == RC) m_err = 1;
      else begin
        push_rule(m_val, m_mask);
        m_count++;
      end
    end
    csr_wr(4'h8, {30'h0, c}, acc);
  endtask

  task automatic check_status(input string nm);
    logic [31:0] s;
    bit idle;
    idle = 0;
    for (int i = 0; i < 100 && !idle; i++) begin
      csr_rd(4'h9, s);
      if (!s[0]) idle = 1;
    end
    if (!idle) timeout(nm);
    else chk(nm, s, {16'h0, 8'(m_count), 5'h0, m_err[0], (m_count == RC), 1'b0});
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int acc, t, base;
    logic [127:0] v;
    bit ok;
    reset = 1'b1;
    addr = '0; write = 0; read = 0; wdata = '0;
    p_addr = '0; p_write = 0; p_read = 0; p_wdata = '0;
    m_val = '0; m_mask = '0; m_count = 0; m_err = 0; tclr_exp = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_upd_write", {31'h0, upd_write}, 32'h0);
    chk("reset_upd_writedata", upd_wdata, 32'h0);
    chk("reset_table_clear", {31'h0, tclr}, 32'h0);
    chk("reset_readdata", readdata, 32'h0);
    @(negedge clock) reset = 1'b0;
    check_status("status_after_reset");

    // Pacing instance: commit, then a staging write that must stall until the sequencer is idle.
    @(posedge clock); #1;
    p_addr = 4'h8; p_wdata = 32'h1; p_write = 1'b1;
    @(negedge clock);
    t = cyc;
    chk("pace_commit_no_stall", {31'h0, p_waitreq}, 32'h0);
    @(posedge clock); #1;
    p_addr = 4'h0; p_wdata = 32'h1234;
    ok = 0;
    acc = -1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      if (!p_waitreq) begin ok = 1; acc = cyc; end
    end
    @(posedge clock); #1;
    p_write = 1'b0;
    chk("pace_stall_release", 32'(acc), 32'(t + 1 + (2*NWD - 1)*4 + 2));
    chk("pace_write_count", 32'(p_times.size()), 32'(2*NWD));
    if (p_times.size() == 2*NWD) begin
      chk("pace_first_latency", 32'(p_times[0]), 32'(t + 1));
      for (int i = 1; i < 2*NWD; i++) chk("pace_spacing", 32'(p_times[i] - p_times[i-1]), 32'd4);
    end
    @(posedge clock); #1;
    p_addr = 4'h9; p_read = 1'b1;
    @(posedge clock); #1;
    p_read = 1'b0;
    chk("pace_status", p_readdata, 32'h0000_0100);

    // Exact rule, then a staging write that stalls until IDLE.
    v = 128'h00d609b1f0566312153523c089b1f081;
    stage(v, {128{1'b1}});
    do_cmd(2'b01, t);
    csr_wr(4'h0, v[31:0], acc);
    chk("stall_release_cycle", 32'(acc), 32'(t + 1 + (2*NWD - 1)*2 + 2));
    check_status("status_exact_rule");

    // Wildcard rule
    stage(v, '0);
    do_cmd(2'b01, t);
    check_status("status_wildcard");

    // Fill the table with random rules, including junk above the key width.
    while (m_count < RC) begin
      stage(rand128(), rand128());
      do_cmd(2'b01, t);
    end
    check_status("status_full");

    stage(rand128(), rand128());
    do_cmd(2'b01, t);
    repeat (25) @(posedge clock);
    check_status("status_commit_when_full");

    do_cmd(2'b10, t);
    check_status("status_after_clear");
    chk("table_clear_pulses", 32'(tclr_seen), 32'(tclr_exp));
    csr_wr(4'hA, 32'h0, acc);
    m_err = 0;
    check_status("status_after_errclr");

    stage(rand128(), rand128());
    do_cmd(2'b11, t);
    repeat (25) @(posedge clock);
    check_status("status_commit_and_clear");
    chk("table_clear_pulses_both", 32'(tclr_seen), 32'(tclr_exp));
    csr_wr(4'hA, 32'h0, acc);
    m_err = 0;
    check_status("status_errclr_2");

    // Reset in the middle of a stream, on the cycle the 4th word is on the bus.
    stage(rand128(), rand128());
    base = wr_seen;
    do_cmd(2'b01, t);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (wr_seen == base + 3) ok = 1;
    end
    if (!ok) timeout("third_word");
    @(posedge clock);
    @(posedge clock); #2;
    addr = 4'h0; wdata = 32'h0; write = 1'b1;
    reset = 1'b1;
    #1;
    chk("midreset_upd_write", {31'h0, upd_write}, 32'h0);
    chk("midreset_not_busy", {31'h0, waitreq}, 32'h0);
    write = 1'b0;
    expq.delete();
    m_count = 0; m_err = 0; m_val = '0; m_mask = '0;
    @(posedge clock);
    @(negedge clock) reset = 1'b0;
    check_status("status_after_midreset");
    stage(rand128(), rand128());
    do_cmd(2'b01, t);
    check_status("status_after_recommit");

    chk("scoreboard_drained", 32'(expq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
